// File: rtl/mem_pkg.sv
// Shared constants for the CPU data memory: bus geometry, access encodings, default size.
// Latency: n/a (package only).
// Backpressure: n/a; the memory has no handshake and accepts an access every cycle.
package mem_pkg;

  localparam int DATA_W         = 64;
  localparam int ADDR_W         = 64;
  localparam int BYTES_PER_WORD = 8;
  localparam int DEFAULT_DEPTH  = 1024;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // A doubleword access is legal only if all eight bytes land inside the array;
  // any set upper address bit makes the address exceed the limit.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a, input int depth);
    return a <= ADDR_W'(depth - BYTES_PER_WORD);
  endfunction

endpackage

// File: rtl/data_mem_bus_drv.sv
// Tri-state driver placing the assembled read word onto the shared CPU data bus.
// Latency: combinational; the enable follows rst and mem_rw in the same delta.
// Backpressure: none; the bus is released whenever reset is high or the CPU is writing.
module data_mem_bus_drv
  import mem_pkg::*;
(
  input  logic              rst,
  input  logic              mem_rw,
  input  logic [DATA_W-1:0] rdata,
  output tri   [DATA_W-1:0] mem_data
);

  logic drv_en;

  // Drive only on a read outside reset so the CPU never contends with the memory.
  assign drv_en   = !rst && (mem_rw == MEM_READ);
  assign mem_data = drv_en ? rdata : {DATA_W{1'bz}};

endmodule

// File: rtl/data_mem.sv
// Byte-addressed little-endian doubleword data memory sharing one bidirectional bus with the CPU.
// Latency: reads combinational (zero cycles); writes commit on the rising clock edge.
// Backpressure: none; out-of-range reads return zero and out-of-range writes are dropped whole.
module data_mem
  import mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
)(
  inout  tri   [DATA_W-1:0] mem_data,
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] addr
);

  localparam int IDX_W = $clog2(DEPTH);

  // Byte storage; reset deliberately leaves it untouched.
  logic [7:0]        DM [0:DEPTH-1];

  logic              addr_ok;
  logic [IDX_W-1:0]  base_idx;
  logic              wr_en;
  logic [DATA_W-1:0] rdata;

  // Decode the access: range check and write qualification (reset cancels a pending write).
  always_comb begin
    addr_ok  = addr_in_range(addr, DEPTH);
    base_idx = addr[IDX_W-1:0];
    wr_en    = !rst && (mem_rw == MEM_WRITE) && addr_ok;
  end

  // Assemble the little-endian doubleword starting at any byte offset; zero when out of range.
  always_comb begin
    rdata = '0;
    if (addr_ok) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        rdata[8*i +: 8] = DM[base_idx + IDX_W'(i)];
      end
    end
  end

  // Commit all eight bus bytes together, or none of them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        DM[base_idx + IDX_W'(i)] <= mem_data[8*i +: 8];
      end
    end
  end

  data_mem_bus_drv u_bus_drv (
    .rst      (rst),
    .mem_rw   (mem_rw),
    .rdata    (rdata),
    .mem_data (mem_data)
  );

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: CPU-side bus driver, byte-array reference model, read scoreboard.
// Latency: reads sampled 1 time unit after stimulus; writes checked after one posedge.
// Backpressure: none; the bus carries a pull-up so a released bus reads as all ones.
module tb_data_mem;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst;
  logic        mem_rw;
  logic [63:0] addr;
  logic        cpu_drv;
  logic [63:0] cpu_dat;
  tri1  [63:0] mem_data;

  assign mem_data = cpu_drv ? cpu_dat : 64'bz;

  data_mem #(.DEPTH(DEPTH)) dut (
    .mem_data (mem_data),
    .clk      (clk),
    .rst      (rst),
    .mem_rw   (mem_rw),
    .addr     (addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q [$];
  logic [7:0]  model_mem [0:DEPTH-1];
  logic [63:0] rnd_addr [6];

  function automatic logic [63:0] model_word(input logic [63:0] a);
    logic [63:0] w;
    w = 64'h0;
    if (a <= 64'(DEPTH - 8)) begin
      for (int i = 0; i < 8; i++) w[8*i +: 8] = model_mem[int'(a[9:0]) + i];
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_pop(input string tag);
    logic [63:0] expv;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=empty-queue expected=entry", tag);
    end else begin
      expv = exp_q.pop_front();
      check(tag, mem_data, expv);
    end
  endtask

  // Read with an explicit expected value.
  task automatic read_exp(input logic [63:0] a, input logic [63:0] expv, input string tag);
    addr   = a;
    mem_rw = 1'b0;
    exp_q.push_back(expv);
    #1;
    check_pop(tag);
  endtask

  // Read with the expected value taken from the reference model.
  task automatic read_model(input logic [63:0] a, input string tag);
    read_exp(a, model_word(a), tag);
  endtask

  task automatic bus_write(input logic [63:0] a, input logic [63:0] d);
    @(negedge clk);
    addr    = a;
    mem_rw  = 1'b1;
    cpu_dat = d;
    cpu_drv = 1'b1;
    if (a <= 64'(DEPTH - 8)) begin
      for (int i = 0; i < 8; i++) model_mem[int'(a[9:0]) + i] = d[8*i +: 8];
    end
    @(posedge clk);
    #1;
    cpu_drv = 1'b0;
    mem_rw  = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    mem_rw  = 1'b0;
    addr    = 64'h0;
    cpu_drv = 1'b0;
    cpu_dat = 64'h0;
    #1;
    check("reset_bus_released", mem_data, {64{1'b1}});
    #11;
    rst = 1'b0;

    // Preload the first doubleword through the bus and read it back combinationally.
    bus_write(64'd0, 64'h0807060504030201);
    read_exp(64'd0, 64'h0807060504030201, "preload_rd");
    for (int i = 0; i < 8; i++) check($sformatf("preload_DM%0d", i), 64'(dut.DM[i]), 64'(i + 1));

    // Aligned write then read.
    bus_write(64'd16, 64'hDEADBEEFCAFEF00D);
    read_exp(64'd16, 64'hDEADBEEFCAFEF00D, "wr16_rd");
    check("wr16_DM16", 64'(dut.DM[16]), 64'h0D);
    check("wr16_DM23", 64'(dut.DM[23]), 64'hDE);

    // Write mode releases the bus; switching back to read drives it in the same step.
    addr   = 64'd0;
    mem_rw = 1'b1;
    #1;
    check("write_mode_released", mem_data, {64{1'b1}});
    mem_rw = 1'b0;
    #1;
    check("rw_toggle_read", mem_data, 64'h0807060504030201);

    // Asynchronous reset during a read releases the bus without a clock.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_read_released", mem_data, {64{1'b1}});
    #1;
    rst = 1'b0;
    #1;
    check("rst_release_read", mem_data, 64'h0807060504030201);

    // Reset asserted mid-cycle during a write, held over the posedge: no bytes change.
    @(negedge clk);
    addr    = 64'd16;
    mem_rw  = 1'b1;
    cpu_dat = 64'h0123456789ABCDEF;
    cpu_drv = 1'b1;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    cpu_drv = 1'b0;
    mem_rw  = 1'b0;
    read_exp(64'd16, 64'hDEADBEEFCAFEF00D, "rst_write_dropped");
    read_exp(64'd0, 64'h0807060504030201, "rst_preserves_DM");

    // Writes resume at the first posedge after reset.
    bus_write(64'd40, 64'h5A5A0F0FA5A5F0F0);
    read_model(64'd40, "post_rst_write");

    // Misaligned write and read.
    bus_write(64'd3, 64'h1122334455667788);
    read_exp(64'd3, 64'h1122334455667788, "misaligned_rd");
    check("misaligned_DM3", 64'(dut.DM[3]), 64'h88);
    read_model(64'd0, "misaligned_overlap");

    // Top-of-array boundary and out-of-range behaviour.
    bus_write(64'(DEPTH - 8), 64'hA1A2A3A4A5A6A7A8);
    read_exp(64'(DEPTH - 8), 64'hA1A2A3A4A5A6A7A8, "last_word_rd");
    read_exp(64'(DEPTH - 4), 64'h0, "oor_read_zero");
    read_exp(64'(DEPTH - 7), 64'h0, "oor_read_edge");
    read_exp(64'h0000_0001_0000_0000, 64'h0, "oor_read_upper");
    bus_write(64'(DEPTH - 4), 64'hFFEEDDCCBBAA9988);
    for (int i = DEPTH - 8; i < DEPTH; i++)
      check($sformatf("oor_write_DM%0d", i), 64'(dut.DM[i]), 64'(model_mem[i]));
    bus_write(64'h8000_0000_0000_0010, 64'h1111111111111111);
    read_exp(64'd16, 64'hDEADBEEFCAFEF00D, "oor_write_upper");

    // Random in-range writes, then model-checked reads of the same addresses.
    for (int k = 0; k < 6; k++) begin
      rnd_addr[k] = 64'($urandom_range(0, DEPTH - 8));
      bus_write(rnd_addr[k], {$urandom, $urandom});
    end
    for (int k = 0; k < 6; k++) read_model(rnd_addr[k], $sformatf("rand_rd%0d", k));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
